// File: rtl/xf_matrix_port_arbiter.sv
// ---------------------------------------------------------------------------
// xf_matrix_port_arbiter
//   Shares the single XF matrix-memory row-read port among NUM_REQ transform
//   units (0 = position, 1 = normal, 2 = texcoord). One row read is granted
//   per cycle by round-robin. The winner's index is recorded in an in-order
//   tag FIFO so that each returning row is steered back to the unit that
//   issued it.
//
//   Optional feature (macro XF_MATRIX_ARB_BURST_LOCK_EN):
//     After a grant, the winner keeps top priority for up to BURST_LEN
//     consecutive granted beats while its request stays high. This keeps a
//     3-row matrix fetch contiguous in the memory stream.
//
// Ports
//   clk          in   system clock
//   resetn       in   synchronous active-low reset
//   reqEnable    in   [NUM_REQ]         per-requester row-read request (level)
//   reqAddr      in   [NUM_REQ*ADDR_W]  packed row addresses, slot i = [i*ADDR_W +: ADDR_W]
//   reqGrant     out  [NUM_REQ]         one-hot, request accepted this cycle (comb)
//   rspData      out  [DATA_W]          returned row, broadcast (registered)
//   rspValid     out  [NUM_REQ]         one-hot owner of rspData (registered)
//   memAddr      out  [ADDR_W]          row address to matrix memory (comb)
//   memEnable    out  1                 read strobe to matrix memory (comb)
//   memData      in   [DATA_W]          row data from memory
//   memValid     in   1                 memory data valid, in issue order
//   errSpurious  out  1                 sticky: memValid seen with no read outstanding
// ---------------------------------------------------------------------------
module xf_matrix_port_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned BURST_LEN   = 3
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          reqEnable,
  input  logic [NUM_REQ*ADDR_W-1:0]   reqAddr,
  output logic [NUM_REQ-1:0]          reqGrant,
  output logic [DATA_W-1:0]           rspData,
  output logic [NUM_REQ-1:0]          rspValid,
  output logic [ADDR_W-1:0]           memAddr,
  output logic                        memEnable,
  input  logic [DATA_W-1:0]           memData,
  input  logic                        memValid,
  output logic                        errSpurious
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  // An illegal parameter set leaves the arbiter idle instead of misbehaving.
  localparam bit CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= 4) &&
                          (OUTSTANDING >= 2) &&
                          ((OUTSTANDING & (OUTSTANDING - 1)) == 0) &&
                          (BURST_LEN >= 1);

  // Per-requester address view of the packed address bus
  logic [ADDR_W-1:0] req_addr_a [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr_split
    assign req_addr_a[gi] = reqAddr[gi*ADDR_W +: ADDR_W];
  end

  // Arbitration state
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  // Tag FIFO state
  logic [IDX_W-1:0]  tag_q [OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Response path state
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               err_q, err_d;

  // Combinational arbitration results
  logic              can_grant_c;
  logic              grant_c;
  logic [IDX_W-1:0]  win_idx_c;
  logic              push_c;
  logic              pop_c;

`ifdef XF_MATRIX_ARB_BURST_LOCK_EN
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

  logic              lock_active_q, lock_active_d;
  logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
  logic [BEAT_W-1:0] lock_beats_q, lock_beats_d;
  logic              lock_hit_c;

  // Locked requester still asking: it owns the port ahead of round-robin
  assign lock_hit_c = lock_active_q && reqEnable[lock_idx_q];
`endif

  // Registered count only: a same-cycle pop never frees a slot for a grant
  assign can_grant_c = CFG_OK && resetn && (count_q < CNT_W'(OUTSTANDING));

  // Round-robin search from rr_ptr_q, wrapping modulo NUM_REQ
  always_comb begin : arb_comb
    int unsigned       sum;
    logic [IDX_W-1:0]  cand;
    logic              found;

    sum       = 0;
    cand      = '0;
    found     = 1'b0;
    win_idx_c = '0;

    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = 32'(rr_ptr_q) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = IDX_W'(sum);
      if (!found && reqEnable[cand]) begin
        found     = 1'b1;
        win_idx_c = cand;
      end
    end

`ifdef XF_MATRIX_ARB_BURST_LOCK_EN
    if (lock_hit_c) begin
      found     = 1'b1;
      win_idx_c = lock_idx_q;
    end
`endif

    grant_c  = can_grant_c && found;
    reqGrant = '0;
    memAddr  = '0;
    if (grant_c) begin
      reqGrant = NUM_REQ'(1) << win_idx_c;
      memAddr  = req_addr_a[win_idx_c];
    end
  end

  assign memEnable = grant_c;
  assign push_c    = grant_c;
  assign pop_c     = memValid && (count_q != '0);

  // Next state: pointer, tag FIFO bookkeeping and response capture
  always_comb begin : next_comb
    rr_ptr_d    = rr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;

    if (push_c) begin
      rr_ptr_d = (win_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_c + IDX_W'(1);
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop_c) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      rsp_valid_d = NUM_REQ'(1) << tag_q[rd_ptr_q];
      rsp_data_d  = memData;
    end

    // Return with nothing outstanding (e.g. in flight across a reset) is dropped
    if (memValid && (count_q == '0)) begin
      err_d = 1'b1;
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read below count_q
  always_ff @(posedge clk) begin
    if (push_c) begin
      tag_q[wr_ptr_q] <= win_idx_c;
    end
  end

`ifdef XF_MATRIX_ARB_BURST_LOCK_EN
  // Lock tracking: a full-FIFO stall neither counts a beat nor releases
  always_comb begin : lock_comb
    lock_active_d = lock_active_q;
    lock_idx_d    = lock_idx_q;
    lock_beats_d  = lock_beats_q;

    if (grant_c) begin
      if (lock_hit_c) begin
        lock_beats_d  = lock_beats_q + BEAT_W'(1);
        lock_active_d = (lock_beats_q + BEAT_W'(1)) < BEAT_W'(BURST_LEN);
      end else begin
        lock_idx_d    = win_idx_c;
        lock_beats_d  = BEAT_W'(1);
        lock_active_d = (BURST_LEN > 1);
      end
    end else if (lock_active_q && !reqEnable[lock_idx_q]) begin
      lock_active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_active_q <= 1'b0;
      lock_idx_q    <= '0;
      lock_beats_q  <= '0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_idx_q    <= lock_idx_d;
      lock_beats_q  <= lock_beats_d;
    end
  end
`endif

  assign rspValid    = rsp_valid_q;
  assign rspData     = rsp_data_q;
  assign errSpurious = err_q;

endmodule

// File: tb/tb_xf_matrix_port_arbiter.sv
module tb_xf_matrix_port_arbiter;

  logic         clk;
  logic         resetn;
  logic [2:0]   reqEnable;
  logic [17:0]  reqAddr;
  logic [2:0]   reqGrant;
  logic [127:0] rspData;
  logic [2:0]   rspValid;
  logic [5:0]   memAddr;
  logic         memEnable;
  logic [127:0] memData;
  logic         memValid;
  logic         errSpurious;

  int n_cmp;
  int n_mis;
  int cyc;
  int lat;

  typedef struct {
    int         due;
    logic [5:0] addr;
  } pend_t;
  pend_t pq[$];

  logic [2:0]  exp_gnt [7];
  logic [2:0]  pat;
  logic [2:0]  er;
  logic [13:0] me_exp;

  xf_matrix_port_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .reqEnable   (reqEnable),
    .reqAddr     (reqAddr),
    .reqGrant    (reqGrant),
    .rspData     (rspData),
    .rspValid    (rspValid),
    .memAddr     (memAddr),
    .memEnable   (memEnable),
    .memData     (memData),
    .memValid    (memValid),
    .errSpurious (errSpurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] row(input logic [5:0] a);
    return {4{26'h2A5F0C3, a}};
  endfunction

  // Address of the requester named by a one-hot grant in the round-robin test
  function automatic logic [5:0] gnt_addr(input logic [2:0] oh);
    case (oh)
      3'b001:  return 6'h00;
      3'b010:  return 6'h10;
      3'b100:  return 6'h20;
      default: return 6'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Close the current cycle: record any issued read, advance to the next
  // cycle, and drive that cycle's memory return from the in-order model.
  task automatic next_cycle();
    if (memEnable === 1'b1) pq.push_back('{cyc + lat, memAddr});
    @(posedge clk);
    #1;
    cyc++;
    memValid = 1'b0;
    memData  = '0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      memValid = 1'b1;
      memData  = row(pq[0].addr);
      void'(pq.pop_front());
    end
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; cyc = 0; lat = 2;
    resetn = 1'b0; reqEnable = 3'b001; reqAddr = '0;
    memValid = 1'b0; memData = '0;

    // Reset: grant and strobe forced low, registers cleared
    next_cycle(); #1;
    chk("rst_gnt", reqGrant, 3'b000);
    chk("rst_men", memEnable, 1'b0);
    chk("rst_rspv", rspValid, 3'b000);
    chk("rst_rspd", rspData, 128'h0);
    chk("rst_err", errSpurious, 1'b0);

    // Single requester, latency 2
    next_cycle(); resetn = 1'b1; reqEnable = 3'b001; reqAddr = 18'h00006; #1;
    chk("t1_gnt0", reqGrant, 3'b001);
    chk("t1_adr0", memAddr, 6'h06);
    chk("t1_men0", memEnable, 1'b1);
    next_cycle(); reqAddr = 18'h00007; #1;
    chk("t1_gnt1", reqGrant, 3'b001);
    chk("t1_adr1", memAddr, 6'h07);
    next_cycle(); reqAddr = 18'h00008; #1;
    chk("t1_adr2", memAddr, 6'h08);
    chk("t1_rspv2", rspValid, 3'b000);
    next_cycle(); reqEnable = 3'b000; #1;
    chk("t1_men3", memEnable, 1'b0);
    chk("t1_rspv3", rspValid, 3'b001);
    chk("t1_rspd3", rspData, row(6'h06));
    next_cycle(); #1;
    chk("t1_rspv4", rspValid, 3'b001);
    chk("t1_rspd4", rspData, row(6'h07));
    next_cycle(); #1;
    chk("t1_rspv5", rspValid, 3'b001);
    chk("t1_rspd5", rspData, row(6'h08));
    next_cycle(); #1;
    chk("t1_rspv6", rspValid, 3'b000);
    chk("t1_rspd6", rspData, row(6'h08));

    // Multi-requester arbitration, latency 1
`ifdef XF_MATRIX_ARB_BURST_LOCK_EN
    pat = 3'b011;
    exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b001};
`else
    pat = 3'b111;
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
`endif
    lat = 1;
    next_cycle(); resetn = 1'b0; reqEnable = 3'b000; #1;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      resetn    = 1'b1;
      reqAddr   = {6'h20, 6'h10, 6'h00};
      reqEnable = (c < 7) ? pat : 3'b000;
      #1;
      if (c < 7) begin
        chk($sformatf("rr_gnt%0d", c), reqGrant, exp_gnt[c]);
        chk($sformatf("rr_adr%0d", c), memAddr, gnt_addr(exp_gnt[c]));
      end
      er = 3'b000;
      if (c >= 2 && c <= 8) er = exp_gnt[c-2];
      chk($sformatf("rr_rspv%0d", c), rspValid, er);
      if (er != 3'b000) chk($sformatf("rr_rspd%0d", c), rspData, row(gnt_addr(er)));
    end

    // FIFO full: latency 8, four reads fill the tag FIFO
    lat = 8;
    me_exp = 14'b01111000001111;
    for (int c = 0; c < 14; c++) begin
      next_cycle(); reqEnable = 3'b001; reqAddr = 18'h00031; #1;
      chk($sformatf("full_men%0d", c), memEnable, me_exp[c]);
      chk($sformatf("full_gnt%0d", c), reqGrant, {2'b00, me_exp[c]});
      er = (c >= 9 && c <= 12) ? 3'b001 : 3'b000;
      chk($sformatf("full_rspv%0d", c), rspValid, er);
    end
    chk("full_rspd", rspData, row(6'h31));
    for (int i = 0; i < 12; i++) begin
      next_cycle(); reqEnable = 3'b000; #1;
      er = (i >= 4 && i <= 7) ? 3'b001 : 3'b000;
      chk($sformatf("drain_rspv%0d", i), rspValid, er);
    end
    chk("drain_err", errSpurious, 1'b0);

    // Spurious return with nothing outstanding
    next_cycle(); memValid = 1'b1; memData = '1; #1;
    chk("sp_err0", errSpurious, 1'b0);
    next_cycle(); #1;
    chk("sp_rspv", rspValid, 3'b000);
    chk("sp_err1", errSpurious, 1'b1);
    chk("sp_rspd", rspData, row(6'h31));
    next_cycle(); #1;
    chk("sp_err2", errSpurious, 1'b1);
    next_cycle(); resetn = 1'b0; #1;
    next_cycle(); resetn = 1'b1; #1;
    chk("sp_err_rst", errSpurious, 1'b0);
    chk("sp_rspd_rst", rspData, 128'h0);

    // Reset with three reads in flight, latency 6
    lat = 6;
    reqAddr = {6'h22, 6'h11, 6'h05};
    next_cycle(); reqEnable = 3'b100; #1;
    chk("mr_gnt0", reqGrant, 3'b100);
    next_cycle(); reqEnable = 3'b001; #1;
    chk("mr_gnt1", reqGrant, 3'b001);
    next_cycle(); reqEnable = 3'b010; #1;
    chk("mr_gnt2", reqGrant, 3'b010);
    next_cycle(); resetn = 1'b0; reqEnable = 3'b111; #1;
    chk("mr_gnt_rst", reqGrant, 3'b000);
    chk("mr_men_rst", memEnable, 1'b0);
    next_cycle(); resetn = 1'b1; reqEnable = 3'b000; #1;
    chk("mr_rspv4", rspValid, 3'b000);
    for (int c = 5; c <= 10; c++) begin
      next_cycle(); #1;
      chk($sformatf("mr_rspv%0d", c), rspValid, 3'b000);
      chk($sformatf("mr_err%0d", c), errSpurious, (c >= 7) ? 1'b1 : 1'b0);
    end
    // Pointer back at 0: requesters 0 and 2 both asking, 0 wins
    next_cycle(); reqEnable = 3'b101; reqAddr = {6'h22, 6'h11, 6'h05}; #1;
    chk("mr_gnt_ptr", reqGrant, 3'b001);
    chk("mr_adr_ptr", memAddr, 6'h05);
    next_cycle(); reqEnable = 3'b000; #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
